// File: rtl/auc_pkg.sv
// Shared constants for the AUC command path: mode codes, operand-RAM map,
// per-mode word counts and the decoder state encoding.
package auc_pkg;

    // Mode codes as carried on auc_mode
    localparam int unsigned MODE_RAND = 0;
    localparam int unsigned MODE_INVS = 1;
    localparam int unsigned MODE_R    = 2;
    localparam int unsigned MODE_S    = 3;
    localparam int unsigned MODE_WMUL = 4;
    localparam int unsigned MODE_MMUL = 5;

    // Operand-RAM addresses
    localparam int unsigned ADDR_X_G    = 0;
    localparam int unsigned ADDR_Y_G    = 1;
    localparam int unsigned ADDR_K_NUM  = 11;
    localparam int unsigned ADDR_HASH   = 16;
    localparam int unsigned ADDR_PKEY   = 17;
    localparam int unsigned ADDR_ZRRAM  = 18;
    localparam int unsigned ADDR_ONERAM = 19;

    // Expected words per burst
    localparam int unsigned EXP_DUMMY = 1;
    localparam int unsigned EXP_S     = 2;
    localparam int unsigned EXP_WMUL  = 5;
    localparam int unsigned EXP_MMUL  = 4;

    // Word index that carries the scalar k
    localparam int unsigned SCL_WMUL = 4;
    localparam int unsigned SCL_MMUL = 3;

    // Decoder states
    typedef logic [2:0] auc_state_t;
    localparam auc_state_t StIdle  = 3'd0;
    localparam auc_state_t StRecv  = 3'd1;
    localparam auc_state_t StCheck = 3'd2;
    localparam auc_state_t StFire  = 3'd3;
    localparam auc_state_t StErr   = 3'd4;

endpackage

// File: rtl/auc_addr_map.sv
// Combinational (mode, word index) -> operand-RAM address lookup with the
// per-mode expected word count, legality and scalar-word flag.
module auc_addr_map
    import auc_pkg::*;
#(
    parameter int unsigned ADDR = 5,
    parameter int unsigned MW   = 3,
    parameter int unsigned IW   = 4
) (
    input  logic [MW-1:0]   mode,
    input  logic [IW-1:0]   idx,
    output logic [ADDR-1:0] addr,
    output logic            in_range,
    output logic            is_scalar,
    output logic [IW-1:0]   expected,
    output logic            legal
);

    localparam logic [ADDR-1:0] BLNK = {ADDR{1'b1}};

    always_comb begin
        addr      = BLNK;
        legal     = 1'b1;
        expected  = '0;
        is_scalar = 1'b0;
        case (mode)
            MW'(MODE_RAND), MW'(MODE_INVS), MW'(MODE_R): begin
                expected = IW'(EXP_DUMMY);
            end
            MW'(MODE_S): begin
                expected = IW'(EXP_S);
                case (idx)
                    IW'(0):  addr = ADDR'(ADDR_HASH);
                    IW'(1):  addr = ADDR'(ADDR_PKEY);
                    default: addr = BLNK;
                endcase
            end
            MW'(MODE_WMUL): begin
                expected  = IW'(EXP_WMUL);
                is_scalar = (idx == IW'(SCL_WMUL));
                case (idx)
                    IW'(0):  addr = ADDR'(ADDR_ZRRAM);
                    IW'(1):  addr = ADDR'(ADDR_ONERAM);
                    IW'(2):  addr = ADDR'(ADDR_X_G);
                    IW'(3):  addr = ADDR'(ADDR_Y_G);
                    IW'(4):  addr = ADDR'(ADDR_K_NUM);
                    default: addr = BLNK;
                endcase
            end
            MW'(MODE_MMUL): begin
                expected  = IW'(EXP_MMUL);
                is_scalar = (idx == IW'(SCL_MMUL));
                case (idx)
                    IW'(0):  addr = ADDR'(ADDR_ZRRAM);
                    IW'(1):  addr = ADDR'(ADDR_ONERAM);
                    IW'(2):  addr = ADDR'(ADDR_X_G);
                    IW'(3):  addr = ADDR'(ADDR_K_NUM);
                    default: addr = BLNK;
                endcase
            end
            default: begin
                legal = 1'b0;
            end
        endcase

        in_range = legal && (idx < expected);
        // Out-of-range words are discarded, never treated as scalar
        if (!in_range) begin
            addr      = BLNK;
            is_scalar = 1'b0;
        end
    end

endmodule

// File: rtl/auc_cmd_decoder.sv
// AUC host-bus command decoder: routes operand bursts into the ECC operand RAM,
// validates burst shape and fires a one-cycle enable for the selected function.
module auc_cmd_decoder
    import auc_pkg::*;
#(
    parameter int unsigned WIDTH = 256,
    parameter int unsigned ADDR  = 5,
    parameter int unsigned MW    = 3,
    parameter int unsigned MAXW  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 auc_vld,
    output logic                 auc_rdy,
    input  logic                 auc_last,
    input  logic [MW-1:0]        auc_mode,
    input  logic [WIDTH-1:0]     auc_dat,
    input  logic                 core_busy,
    output logic [(2**MW)-1:0]   en_op,
    output logic                 dec_wen,
    output logic [ADDR-1:0]      dec_wadd,
    output logic [WIDTH-1:0]     dec_wdat,
    output logic [WIDTH-1:0]     dec_rannum,
    output logic                 dec_ranvld,
    output logic                 dec_err
);

    localparam int unsigned     NMODE = 2**MW;
    localparam int unsigned     IW    = $clog2(MAXW) + 1;
    localparam logic [ADDR-1:0] BLNK  = {ADDR{1'b1}};

    auc_state_t       state_q, state_d;
    logic [MW-1:0]    mode_q, mode_d;
    logic [IW-1:0]    cnt_q, cnt_d;
    logic             overrun_q, overrun_d;
    logic [WIDTH-1:0] shadow_q;

    logic             wen_q;
    logic [ADDR-1:0]  wadd_q;
    logic [WIDTH-1:0] wdat_q;
    logic [NMODE-1:0] en_op_q;
    logic             ranvld_q;
    logic [WIDTH-1:0] rannum_q;
    logic             err_q;

    logic             rdy;
    logic             accept;
    logic             good;

    logic [MW-1:0]    map_mode;
    logic [IW-1:0]    map_idx;
    logic [ADDR-1:0]  map_addr;
    logic             map_in_range;
    logic             map_is_scalar;
    logic [IW-1:0]    map_expected;
    logic             map_legal;

    // In IDLE the first word is mapped with the live mode; afterwards the latched one
    always_comb begin
        map_mode = mode_q;
        map_idx  = cnt_q;
        if (state_q == StIdle) begin
            map_mode = auc_mode;
            map_idx  = '0;
        end
    end

    auc_addr_map #(
        .ADDR (ADDR),
        .MW   (MW),
        .IW   (IW)
    ) u_addr_map (
        .mode      (map_mode),
        .idx       (map_idx),
        .addr      (map_addr),
        .in_range  (map_in_range),
        .is_scalar (map_is_scalar),
        .expected  (map_expected),
        .legal     (map_legal)
    );

    always_comb begin
        rdy = 1'b0;
        case (state_q)
            StIdle:  rdy = !core_busy;
            StRecv:  rdy = 1'b1;
            default: rdy = 1'b0;
        endcase
        if (rst) begin
            rdy = 1'b0;
        end
    end

    assign auc_rdy = rdy;
    assign accept  = auc_vld && rdy;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        overrun_d = overrun_q;
        // Only meaningful in CHECK, where the map sees (mode_q, cnt_q)
        good      = map_legal && !overrun_q && (cnt_q == map_expected);
        case (state_q)
            StIdle: begin
                if (accept) begin
                    mode_d    = auc_mode;
                    cnt_d     = IW'(1);
                    overrun_d = (map_idx >= map_expected);
                    state_d   = auc_last ? StCheck : StRecv;
                end
            end
            StRecv: begin
                if (accept) begin
                    cnt_d     = (cnt_q == IW'(MAXW)) ? cnt_q : cnt_q + IW'(1);
                    overrun_d = overrun_q || (map_idx >= map_expected);
                    if (auc_last) begin
                        state_d = StCheck;
                    end
                end
            end
            StCheck: begin
                state_d = good ? StFire : StErr;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            mode_q    <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
            shadow_q  <= '0;
            wen_q     <= 1'b0;
            wadd_q    <= BLNK;
            wdat_q    <= '0;
            en_op_q   <= '0;
            ranvld_q  <= 1'b0;
            rannum_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;

            wen_q <= accept && map_in_range && (map_addr != BLNK);
            if (accept) begin
                wadd_q <= map_addr;
                wdat_q <= auc_dat;
            end
            if (accept && map_is_scalar) begin
                shadow_q <= auc_dat;
            end

            // Pulses are registered on the CHECK exit so they appear in FIRE/ERR
            en_op_q  <= '0;
            ranvld_q <= 1'b0;
            err_q    <= 1'b0;
            if (state_q == StCheck) begin
                if (good) begin
                    en_op_q  <= NMODE'(1) << mode_q;
                    ranvld_q <= 1'b1;
                    rannum_q <= shadow_q;
                end else begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign dec_wen    = wen_q;
    assign dec_wadd   = wadd_q;
    assign dec_wdat   = wdat_q;
    assign en_op      = en_op_q;
    assign dec_ranvld = ranvld_q;
    assign dec_rannum = rannum_q;
    assign dec_err    = err_q;

endmodule

// File: doc/auc_cmd_decoder.md
# auc_cmd_decoder

Parametrised command decoder between the host bus (AUC) and the ECC core. It accepts operand bursts over a valid/ready handshake and routes each word to its operand-RAM address from a per-mode map. It checks burst length and mode legality, publishes the scalar only for well-formed commands, and issues a one-cycle enable for the selected core function. It replaces the fixed-count start-level decoder. WMUL is restored as a supported mode.

## Interface
Parameters:
- `WIDTH`, 256, operand word width
- `ADDR`, 5, operand-RAM address width; `BLNK` = 2^ADDR-1 is the discard address
- `MW`, 3, mode field width; `NMODE` = 2^MW
- `MAXW`, 8, maximum counted words per burst; index counter width = $clog2(MAXW)+1

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `auc_vld`  in  1  word valid
- `auc_rdy`  out  1  decoder can accept a word
- `auc_last`  in  1  final word of the command
- `auc_mode`  in  MW  mode; sampled on the first word of a burst only
- `auc_dat`  in  WIDTH  operand word
- `core_busy`  in  1  core is running; blocks the start of a new burst
- `en_op`  out  NMODE  one-hot function-enable pulse, bit index = mode
- `dec_wen`  out  1  operand-RAM write enable
- `dec_wadd`  out  ADDR  write address
- `dec_wdat`  out  WIDTH  write data
- `dec_rannum`  out  WIDTH  scalar (k) for the core
- `dec_ranvld`  out  1  scalar-update pulse
- `dec_err`  out  1  one-cycle pulse marking a rejected command

## Operation
- States:
  - IDLE:
    - `auc_rdy` = !core_busy.
    - Accept (vld&rdy): latch mode, idx=0, overrun=0.
    - Then go to RECV, or to CHECK if `auc_last`.
  - RECV:
    - `auc_rdy` = 1; `core_busy` is ignored mid-burst.
    - Each accept increments idx, saturating at MAXW.
    - Go to CHECK on an accepted word with `auc_last`.
  - CHECK:
    - `auc_rdy` = 0.
    - Good = mode legal && !overrun && words == expected(mode).
    - Good → FIRE; else → ERR.
  - FIRE: `auc_rdy` = 0; pulse `en_op[mode]` and `dec_ranvld`; commit the shadow scalar to `dec_rannum`; go to IDLE.
  - ERR: `auc_rdy` = 0; pulse `dec_err`; `en_op`, `dec_ranvld` and `dec_rannum` are untouched; go to IDLE.
- Per-mode map: (mode, idx) → address; expected word count; scalar index.

| Mode | Code | Expected words | Word map (idx0, idx1, …) | Scalar idx |
|---|---|---|---|---|
| RAND | 0 | 1 dummy | BLNK | none |
| INVS | 1 | 1 dummy | BLNK | none |
| R | 2 | 1 dummy | BLNK | none |
| S | 3 | 2 | HASH(16), PKEY(17) | none |
| WMUL | 4 | 5 | ZRRAM(18), ONERAM(19), X_G(0), Y_G(1), K_NUM(11) | 4 |
| MMUL | 5 | 4 | ZRRAM, ONERAM, X_G, K_NUM | 3 |
| 6, 7 | — | illegal, expected = 0 | — | — |

- Write rule: a word is written only if the mode is legal and idx < expected and the mapped address != BLNK.
  - Otherwise `dec_wen` = 0, and the word is dropped.
  - A word with idx >= expected sets overrun.
- The scalar word is always written to K_NUM and also loaded into an internal shadow register. Only FIRE publishes the shadow.
- Already-written RAM words of a rejected command are not rolled back; the core is not enabled, so they are simply overwritten by the next command.

## Timing
- Write latency: a word accepted at cycle T drives `dec_wen`/`dec_wadd`/`dec_wdat` at T+1, all registered.
- A last word accepted at T gives CHECK at T+1 and the `en_op` or `dec_err` pulse at T+2. `auc_rdy` returns at T+3 at the earliest.
- Minimum command spacing: 1 + 2 dead cycles after the last word.
- Reset values:
  - `auc_rdy` = 0 during reset; IDLE follows reset.
  - `en_op` = 0, `dec_err` = 0, `dec_ranvld` = 0.
  - `dec_wen` = 0, `dec_wadd` = BLNK, `dec_wdat` = 0, `dec_rannum` = 0, shadow = 0.
- Reset mid-burst: abort immediately, with no enable and no error pulse. The partial RAM writes already issued stand.
- `auc_vld` without rdy: no effect; words are held by the source.
- Simultaneous `core_busy` rise and first-word accept in IDLE: `core_busy` wins because it gates rdy combinationally; no accept.
- Changes of `auc_mode` after the first word are ignored.

## Structure
- Shared package `auc_pkg` holds:
  - mode codes and the RAM address constants;
  - the expected-count and scalar-index constants;
  - the state enum.
- One sub-module `auc_addr_map`: combinational (mode, idx) → {addr, in_range, is_scalar, expected, legal}. It is reused by the future readback decoder.

## Test plan
- MMUL, 4 words D0..D3 with last on D3 →
  - writes to addrs 18, 19, 0, 11 at T+1..T+4;
  - `en_op` = 0x20 and `dec_ranvld` = 1 at 2 cycles after the last accept;
  - `dec_rannum` = D3.
- WMUL, 5 words →
  - writes to 18, 19, 0, 1, 11;
  - `en_op[4]` pulse;
  - `dec_rannum` = word 4.
- S with only 1 word (last early) →
  - write to 16 only;
  - `dec_err` pulse, no `en_op`;
  - `dec_rannum` unchanged.
- MMUL with 6 words →
  - words 4 and 5 are not written;
  - `dec_err` pulse;
  - previous `dec_rannum` kept.
- Mode 7, single word →
  - no write;
  - `dec_err`.
- RAND dummy word → no write, `en_op` = 0x01.
- `core_busy` = 1 in IDLE → `auc_rdy` = 0 and a held word is not accepted until busy drops.
- Reset asserted after 2 MMUL words → no pulse of any kind; the next full command works.
